mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 118 +++++++++++
 tb/tb_mult_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a single shared multiplier.
// One multiply is in flight at a time; a hung multiplier is timed out and flagged in err.
module mult_arbiter #(
   parameter int unsigned FRACW   = 16,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned WIDTH  = FRACW + 1,
   localparam int unsigned OUTW   = 2 * WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0Valid,
   input  logic             req1Valid,
   output logic             req0Ready,
   output logic             req1Ready,
   input  logic [WIDTH-1:0] req0A,
   input  logic [WIDTH-1:0] req0B,
   input  logic [WIDTH-1:0] req1A,
   input  logic [WIDTH-1:0] req1B,
   output logic             resp0Valid,
   output logic             resp1Valid,
   input  logic             resp0Ready,
   input  logic             resp1Ready,
   output logic [OUTW-1:0]  resp0Prod,
   output logic [OUTW-1:0]  resp1Prod,
   output logic [WIDTH-1:0] mulIn1,
   output logic [WIDTH-1:0] mulIn2,
   output logic             start,
   input  logic             done,
   input  logic [OUTW-1:0]  mulOut,
   output logic             busy,
   output logic             err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       r_state;
   logic             r_ptr;
   logic             r_owner;
   logic             r_err;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [OUTW-1:0]  r_prod;
   logic [CW-1:0]    r_cnt;

   logic w_idle;
   logic w_grant0;
   logic w_grant1;
   logic w_resp_hs;

   // Readies are masked during reset so nothing is accepted and then silently dropped.
   assign w_idle    = (r_state == S_IDLE) && !reset;
   assign w_grant0  = w_idle && req0Valid && (!req1Valid || !r_ptr);
   assign w_grant1  = w_idle && req1Valid && (!req0Valid || r_ptr);
   assign w_resp_hs = (r_state == S_RESP) && (r_owner ? resp1Ready : resp0Ready);

   assign req0Ready  = w_grant0;
   assign req1Ready  = w_grant1;
   assign resp0Valid = (r_state == S_RESP) && !r_owner;
   assign resp1Valid = (r_state == S_RESP) && r_owner;
   assign resp0Prod  = r_prod;
   assign resp1Prod  = r_prod;
   assign mulIn1     = r_a;
   assign mulIn2     = r_b;
   assign start      = (r_state == S_ISSUE);
   assign busy       = (r_state != S_IDLE);
   assign err        = r_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 1'b0;
         r_owner <= 1'b0;
         r_err   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_a     <= w_grant1 ? req1A : req0A;
                  r_b     <= w_grant1 ? req1B : req0B;
                  r_owner <= w_grant1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // done wins over a timeout landing in the same cycle
               if (done) begin
                  r_prod  <= mulOut;
                  r_state <= S_RESP;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_prod  <= '0;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (w_resp_hs) begin
                  r_ptr   <= ~r_owner;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural multiplier with random latency, directed cases,
// randomized traffic, and a round-robin/product reference model.
module tb_mult_arbiter;

   localparam int unsigned FRACW   = 16;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned WIDTH   = FRACW + 1;
   localparam int unsigned OUTW    = 2 * WIDTH;

   logic             clock = 1'b0;
   logic             reset;
   logic             req0Valid, req1Valid, req0Ready, req1Ready;
   logic [WIDTH-1:0] req0A, req0B, req1A, req1B;
   logic             resp0Valid, resp1Valid, resp0Ready, resp1Ready;
   logic [OUTW-1:0]  resp0Prod, resp1Prod;
   logic [WIDTH-1:0] mulIn1, mulIn2;
   logic             start, done, busy, err;
   logic [OUTW-1:0]  mulOut;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int  m_ptr = 0;
   bit  m_err = 0;

   // Multiplier model controls
   bit          mul_hang = 0;
   int          mul_fix  = -1;
   int          mul_cnt  = 0;
   int          mul_lat_last = 0;
   logic [OUTW-1:0] mul_res;
   logic [OUTW-1:0] last_prod;

   mult_arbiter #(.FRACW(FRACW), .TIMEOUT(TIMEOUT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0Valid  (req0Valid),
      .req1Valid  (req1Valid),
      .req0Ready  (req0Ready),
      .req1Ready  (req1Ready),
      .req0A      (req0A),
      .req0B      (req0B),
      .req1A      (req1A),
      .req1B      (req1B),
      .resp0Valid (resp0Valid),
      .resp1Valid (resp1Valid),
      .resp0Ready (resp0Ready),
      .resp1Ready (resp1Ready),
      .resp0Prod  (resp0Prod),
      .resp1Prod  (resp1Prod),
      .mulIn1     (mulIn1),
      .mulIn2     (mulIn2),
      .start      (start),
      .done       (done),
      .mulOut     (mulOut),
      .busy       (busy),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Shared multiplier: sees start at the ISSUE cycle, raises done for one cycle
   // after 1..4 WAIT cycles; mulOut carries junk whenever done is low.
   initial begin
      int lat;
      done   = 1'b0;
      mulOut = '0;
      forever begin
         @(negedge clock);
         done   = 1'b0;
         mulOut = OUTW'({$urandom, $urandom});
         if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin
               done   = 1'b1;
               mulOut = mul_res;
            end
         end
         if (start && !mul_hang) begin
            lat          = (mul_fix >= 0) ? mul_fix : int'($urandom_range(0, 3));
            mul_cnt      = lat + 1;
            mul_res      = OUTW'(mulIn1) * OUTW'(mulIn2);
            mul_lat_last = lat;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OUTW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return OUTW'(a) * OUTW'(b);
   endfunction

   // Entered just after a posedge. Presents the requested pair and serves every
   // pending request, checking grant order, issue, latency, product and backpressure.
   task automatic run_pair(input bit v0, input bit v1,
                           input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                           input int bp);
      bit p0 = v0;
      bit p1 = v1;
      int own, cnt, exp_lat;
      bit bad_start;
      logic [OUTW-1:0] exp_prod;
      req0A = a0; req0B = b0; req1A = a1; req1B = b1;
      req0Valid = v0; req1Valid = v1;
      while (p0 || p1) begin
         own = (p0 && p1) ? m_ptr : (p0 ? 0 : 1);
         @(negedge clock);
         chk("grant", {62'd0, req1Ready, req0Ready}, (own == 1) ? 64'd2 : 64'd1);
         @(posedge clock); #1;
         if (own == 0) begin p0 = 0; req0Valid = 1'b0; end
         else begin p1 = 0; req1Valid = 1'b0; end
         @(negedge clock);
         chk("issue_start", {63'd0, start}, 64'd1);
         chk("issue_in1", {47'd0, mulIn1}, {47'd0, own ? a1 : a0});
         chk("issue_in2", {47'd0, mulIn2}, {47'd0, own ? b1 : b0});
         chk("issue_rdy", {62'd0, req1Ready, req0Ready}, 64'd0);
         cnt = 1;
         bad_start = 0;
         @(negedge clock);
         while (!(resp0Valid || resp1Valid) && cnt < int'(TIMEOUT) + 20) begin
            if (start) bad_start = 1;
            if (mulIn1 !== (own ? a1 : a0) || mulIn2 !== (own ? b1 : b0)) bad_start = 1;
            @(negedge clock);
            cnt++;
         end
         exp_lat  = mul_hang ? int'(TIMEOUT) + 1 : mul_lat_last + 2;
         exp_prod = mul_hang ? '0 : ref_mul(own ? a1 : a0, own ? b1 : b0);
         if (mul_hang) m_err = 1;
         chk("wait_hold", {63'd0, bad_start}, 64'd0);
         chk("latency", 64'(cnt), 64'(exp_lat));
         chk("err", {63'd0, err}, {63'd0, m_err});
         last_prod = own ? resp1Prod : resp0Prod;
         for (int i = 0; i <= bp; i++) begin
            if (i > 0) @(negedge clock);
            chk("resp_valid", {62'd0, resp1Valid, resp0Valid}, (own == 1) ? 64'd2 : 64'd1);
            chk("resp_prod", 64'(own ? resp1Prod : resp0Prod), 64'(exp_prod));
            chk("resp_quiet", {61'd0, start, req1Ready, req0Ready}, 64'd0);
         end
         if (own == 0) resp0Ready = 1'b1; else resp1Ready = 1'b1;
         @(posedge clock); #1;
         resp0Ready = 1'b0;
         resp1Ready = 1'b0;
         m_ptr = 1 - own;
      end
   endtask

   initial begin
      reset = 1'b1;
      req0Valid = 1'b0; req1Valid = 1'b0;
      req0A = '0; req0B = '0; req1A = '0; req1B = '0;
      resp0Ready = 1'b0; resp1Ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      req0Valid = 1'b1; req0A = 17'd3; req0B = 17'd5;
      @(negedge clock);
      chk("rst_ready", {62'd0, req1Ready, req0Ready}, 64'd0);
      chk("rst_busy_start", {62'd0, busy, start}, 64'd0);
      chk("rst_resp", {62'd0, resp1Valid, resp0Valid}, 64'd0);
      chk("rst_mulin", {30'd0, mulIn1, mulIn2}, 64'd0);
      chk("rst_err", {63'd0, err}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single request accepted in the first cycle out of reset
      run_pair(1, 0, 17'd3, 17'd5, 17'd0, 17'd0, 0);
      chk("single_prod", 64'(last_prod), 64'd15);

      // Simultaneous pairs alternate the winner
      run_pair(1, 1, 17'd7, 17'd9, 17'd2, 17'd4, 0);
      run_pair(1, 1, 17'd7, 17'd9, 17'd2, 17'd4, 0);

      // Backpressure with the other requester waiting
      run_pair(1, 1, 17'd11, 17'd13, 17'd17, 17'd19, 5);

      // Extreme operands
      run_pair(1, 0, 17'h1FFFF, 17'h1FFFF, 17'd0, 17'd0, 0);
      chk("ext_max", 64'(last_prod), 64'h3_FFFC_0001);
      run_pair(0, 1, 17'd0, 17'd0, 17'd0, 17'h1FFFF, 1);
      chk("ext_zero", 64'(last_prod), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 25; n++) begin
         int sel;
         sel = int'($urandom_range(1, 3));
         run_pair(sel[0], sel[1], 17'($urandom), 17'($urandom), 17'($urandom),
                  17'($urandom), int'($urandom_range(0, 2)));
      end

      // Reset mid-WAIT; the stale done then lands while idle
      mul_fix = 10;
      req0A = 17'd100; req0B = 17'd200; req0Valid = 1'b1;
      @(negedge clock);
      chk("mw_grant", {63'd0, req0Ready}, 64'd1);
      @(posedge clock); #1;
      req0Valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("mw_in_wait", {62'd0, busy, start}, 64'd2);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      m_ptr = 0;
      m_err = 0;
      @(negedge clock);
      chk("mw_after_rst", {60'd0, busy, start, resp1Valid, resp0Valid}, 64'd0);
      begin
         bit stray;
         stray = 0;
         repeat (14) begin
            @(negedge clock);
            if (busy || resp0Valid || resp1Valid) stray = 1;
         end
         chk("mw_stale_done", {63'd0, stray}, 64'd0);
      end
      mul_fix = -1;
      @(posedge clock); #1;
      run_pair(0, 1, 17'd0, 17'd0, 17'd6, 17'd6, 0);
      chk("mw_req1", 64'(last_prod), 64'd36);

      // Hung multiplier, then normal traffic with err sticky
      mul_hang = 1;
      run_pair(1, 0, 17'd21, 17'd22, 17'd0, 17'd0, 1);
      mul_hang = 0;
      chk("hang_err", {63'd0, err}, 64'd1);
      run_pair(1, 1, 17'd5, 17'd6, 17'd7, 17'd8, 0);
      for (int n = 0; n < 5; n++) begin
         run_pair(1, 0, 17'($urandom), 17'($urandom), 17'd0, 17'd0, 0);
      end
      chk("err_sticky", {63'd0, err}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
